// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width limits for serial_adder
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // One-hot so busy/done are single-flop decodes.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full-adder cell
module full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic Y,
    output logic cout
);

    assign Y    = A ^ B ^ cin;
    assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one bit per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_illegal_width
            $fatal(1, "serial_adder: WIDTH out of range");
        end
    endgenerate

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            last;
    logic            fa_y;
    logic            fa_cout;

    assign last = (cnt == LAST);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    full_adder u_fa (
        .A    (sa[0]),
        .B    (sb[0]),
        .cin  (carry),
        .Y    (fa_y),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            sa       <= a;
            sb       <= sub ? ~b : b;
            carry    <= sub;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            sum   <= {fa_y, sum[WIDTH-1:1]};
            if (last) begin
                // carry currently holds the carry into the MSB
                cout     <= fa_cout;
                overflow <= carry ^ fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 2, 8 and 32
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [1:0]  sum2;
    logic [7:0]  sum8;
    logic [31:0] sum32;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(a[1:0]), .b(b[1:0]),
        .busy(busy[0]), .done(done[0]), .sum(sum2), .cout(cout[0]), .overflow(ovf[0])
    );
    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .busy(busy[1]), .done(done[1]), .sum(sum8), .cout(cout[1]), .overflow(ovf[1])
    );
    serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .a(a), .b(b),
        .busy(busy[2]), .done(done[2]), .sum(sum32), .cout(cout[2]), .overflow(ovf[2])
    );

    function automatic int wid(input int idx);
        return (idx == 0) ? 2 : (idx == 1) ? 8 : 32;
    endfunction

    function automatic logic [31:0] get_sum(input int idx);
        case (idx)
            0:       return {30'd0, sum2};
            1:       return {24'd0, sum8};
            default: return sum32;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed range test for overflow.
    task automatic model(input int w, input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] es, output logic ec, output logic eo);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint xu   = longint'({32'd0, x}) & m;
        longint yu   = longint'({32'd0, y}) & m;
        longint full = s ? (xu + ((~yu) & m) + 1) : (xu + yu);
        longint sx   = (xu >= half) ? xu - 2 * half : xu;
        longint sy   = (yu >= half) ? yu - 2 * half : yu;
        longint r    = s ? (sx - sy) : (sx + sy);
        es = 32'(full & m);
        ec = ((full >> w) & 1) != 0;
        eo = (r >= half) || (r < -half);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input int idx, input logic [31:0] xa, input logic [31:0] xb, input logic xs);
        a = xa;
        b = xb;
        sub = xs;
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
    endtask

    // c0 is the RUN cycle number at entry; earlier RUN cycles are taken as busy.
    task automatic wait_check(input int idx, input logic [31:0] xa, input logic [31:0] xb,
                              input logic xs, input string tag, input int c0);
        int w = wid(idx);
        int cycles = c0;
        int bcnt = c0 - 1;
        logic [31:0] es;
        logic ec, eo;
        model(w, xa, xb, xs, es, ec, eo);
        while (!done[idx] && cycles <= w + 4) begin
            if (busy[idx]) bcnt++;
            @(negedge clk);
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'(w + 1));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(w));
        check({tag, " sum"}, get_sum(idx), es);
        check({tag, " cout"}, {31'd0, cout[idx]}, {31'd0, ec});
        check({tag, " overflow"}, {31'd0, ovf[idx]}, {31'd0, eo});
    endtask

    initial begin
        int dcount;
        logic [31:0] x, y;
        logic s;
        rst_n = 1'b0;
        start = '0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset busy", {31'd0, busy[i]}, 32'd0);
            check("reset done", {31'd0, done[i]}, 32'd0);
            check("reset sum", get_sum(i), 32'd0);
            check("reset cout", {31'd0, cout[i]}, 32'd0);
            check("reset overflow", {31'd0, ovf[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        launch(1, 32'h35, 32'h4A, 1'b0);
        wait_check(1, 32'h35, 32'h4A, 1'b0, "add35_4a", 1);
        check("add35_4a const", {24'd0, sum8}, 32'h7F);
        @(negedge clk);
        check("done pulse width", {31'd0, done[1]}, 32'd0);
        check("idle busy", {31'd0, busy[1]}, 32'd0);
        check("sum held", {24'd0, sum8}, 32'h7F);

        launch(1, 32'hFF, 32'h01, 1'b0);
        wait_check(1, 32'hFF, 32'h01, 1'b0, "addff_01", 1);
        check("addff_01 const", {23'd0, cout[1], sum8}, 32'h100);
        @(negedge clk);
        launch(1, 32'h7F, 32'h01, 1'b0);
        wait_check(1, 32'h7F, 32'h01, 1'b0, "add7f_01", 1);
        check("add7f_01 const", {23'd0, ovf[1], sum8}, 32'h180);
        @(negedge clk);
        launch(1, 32'h10, 32'h20, 1'b1);
        wait_check(1, 32'h10, 32'h20, 1'b1, "sub10_20", 1);
        check("sub10_20 const", {22'd0, cout[1], ovf[1], sum8}, 32'h0F0);
        @(negedge clk);
        launch(1, 32'h80, 32'h01, 1'b1);
        wait_check(1, 32'h80, 32'h01, 1'b1, "sub80_01", 1);
        check("sub80_01 const", {22'd0, cout[1], ovf[1], sum8}, 32'h37F);
        @(negedge clk);

        launch(1, 32'h01, 32'h02, 1'b0);
        repeat (3) @(negedge clk);
        a = 32'hAA;
        b = 32'h55;
        sub = 1'b0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_check(1, 32'h01, 32'h02, 1'b0, "ignore_start", 5);
        check("ignore_start const", {24'd0, sum8}, 32'h03);
        launch(1, 32'h11, 32'h22, 1'b1);
        check("b2b busy", {31'd0, busy[1]}, 32'd1);
        check("b2b done", {31'd0, done[1]}, 32'd0);
        wait_check(1, 32'h11, 32'h22, 1'b1, "b2b", 1);
        @(negedge clk);

        launch(1, 32'h12, 32'h34, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy[1]}, 32'd0);
        check("abort done", {31'd0, done[1]}, 32'd0);
        check("abort sum", {24'd0, sum8}, 32'd0);
        check("abort cout", {31'd0, cout[1]}, 32'd0);
        check("abort overflow", {31'd0, ovf[1]}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done[1]) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        launch(1, 32'hC3, 32'h5A, 1'b1);
        wait_check(1, 32'hC3, 32'h5A, 1'b1, "after_abort", 1);
        @(negedge clk);

        for (int idx = 0; idx < 3; idx++) begin
            for (int i = 0; i < 1000; i++) begin
                x = $urandom;
                y = $urandom;
                s = 1'($urandom_range(0, 1));
                launch(idx, x, y, s);
                wait_check(idx, x, y, s, $sformatf("rand_w%0d", wid(idx)), 1);
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It takes two WIDTH-bit operands on a start pulse and processes one bit per clock through a single one-bit full-adder cell, holding the carry in a flip-flop. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the multi-bit, sequential generalisation of the team's combinational ripple adder, intended for switch/LED lab tops where area matters more than latency.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all state immediately.
- start  in  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- sub  in  1  mode, latched with start: 0 = A+B, 1 = A−B (two's complement).
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, high while in DONE.
- sum  out  WIDTH  result register; held until the next accepted start.
- cout  out  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  out  1  signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start: latch a into shift register SA, and b (or ~b when sub=1) into SB; carry flop <= sub; bit counter <= 0; clear sum, cout and overflow; go to RUN.
- IDLE without start: stay in IDLE.
- RUN, each cycle:
  - The full-adder cell takes SA[0], SB[0] and carry.
  - The result bit shifts into sum from the MSB end (sum <= {bit, sum[WIDTH-1:1]}).
  - SA and SB shift right; carry <= cout of the cell; counter increments.
- RUN, last bit (counter == WIDTH-1): record carry-in as cmsb; cout <= cell cout; overflow <= cmsb XOR cell cout; go to DONE.
- DONE: done=1 for exactly one cycle.
  - With start: accept as from IDLE and go to RUN (back-to-back operation).
  - Without start: go to IDLE.
- start in RUN is ignored. Operands and sub are not re-sampled.
- a, b and sub may change freely except on the accepting edge.
- Results are undefined while busy. They are valid and stable from the done cycle until the next accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, counter 0, carry 0.
- Latency: start accepted at edge k → busy high from k+1 through k+WIDTH → done high during the cycle following edge k+WIDTH. Total is WIDTH+1 cycles from start to done.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts issued in DONE.
- Reset asserted mid-RUN: aborts immediately and all outputs return to reset values. No done is produced for the aborted operation.
- Counter width is $clog2(WIDTH) bits. Wrap is never reached because RUN exits at WIDTH-1.
- All outputs are registered except busy and done, which decode the state register directly (glitch-free one-hot compare).

## Structure
- Shared package/header serial_adder_pkg holds:
  - the state encoding constants (IDLE, RUN, DONE; one-hot, 3 bits);
  - the WIDTH legality range.
- One sub-module: the existing full_adder cell (ports A, B, cin, Y, cout), instantiated once for the serial datapath.
- FSM, shift registers, counter and carry flop live in serial_adder itself, which targets roughly 150 lines.

## Test plan (WIDTH=8)
- Add 0x35+0x4A: start pulse → done exactly 9 cycles later; sum=0x7F, cout=0, overflow=0; busy high for 8 cycles.
- Add 0xFF+0x01 → sum=0x00, cout=1, overflow=0. Add 0x7F+0x01 → sum=0x80, cout=0, overflow=1.
- Sub 0x10−0x20 → sum=0xF0, cout=0, overflow=0. Sub 0x80−0x01 → sum=0x7F, cout=1, overflow=1.
- Start 0x01+0x02, then pulse start with 0xAA+0x55 at cycle 4 of RUN → ignored; sum=0x03. Issue a new start in the DONE cycle → runs back-to-back with no IDLE cycle.
- Drop rst_n at cycle 5 of RUN → busy, done, sum, cout and overflow are 0 asynchronously. No done pulse follows. The next start after release yields a correct result.
- Sweep WIDTH ∈ {2, 8, 32} with 1000 random a/b/sub each → sum, cout and overflow match a reference model; latency is always WIDTH+1.
